seq_det_ctrl: RTL and testbench

- Programmable serial sequence-detector controller.
- Accepts a pattern configuration through a valid/ready handshake and arms on `start`.
- Scans a gated serial bit stream `x` and emits a Mealy match pulse `z` in overlapping or non-overlapping mode.
- Counts matches and stops with `done` after a programmed number of hits. It sequences the fixed 101 detector use case as the `cfg_len=3`, `cfg_pattern=101` configuration.

---
 rtl/seq_det_ctrl_if.sv | 42 ++++
 rtl/seq_det_ctrl.sv | 164 ++++++++++++++++
 tb/tb_seq_det_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/seq_det_ctrl_if.sv
// Configuration, control and serial-stream bundle for seq_det_ctrl.
//   master : drives cfg_*, start, abort, x, x_valid; observes cfg_ready, cfg_err,
//            z, hit_count, busy, done
//   slave  : the detector controller (mirror of master)
interface seq_det_ctrl_if #(
    parameter int unsigned MAXLEN = 8,
    parameter int unsigned LENW   = 4,
    parameter int unsigned CNTW   = 8
);
    // configuration handshake
    logic              cfg_valid;
    logic              cfg_ready;
    logic [MAXLEN-1:0] cfg_pattern;
    logic [LENW-1:0]   cfg_len;
    logic              cfg_overlap;
    logic [CNTW-1:0]   cfg_target;
    logic              cfg_err;

    // run control and status
    logic              start;
    logic              abort;
    logic [CNTW-1:0]   hit_count;
    logic              busy;
    logic              done;

    // serial stream and match pulse
    logic              x;
    logic              x_valid;
    logic              z;

    modport master (
        output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
        output start, abort, x, x_valid,
        input  cfg_ready, cfg_err, z, hit_count, busy, done
    );

    modport slave (
        input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
        input  start, abort, x, x_valid,
        output cfg_ready, cfg_err, z, hit_count, busy, done
    );
endinterface

// File: rtl/seq_det_ctrl.sv
// Programmable serial sequence-detector controller.
// A pattern (length 1..MAXLEN, MSB received first) is loaded over a valid/ready
// handshake, a run is armed with start, and qualified bits of x are scanned.
// z is a zero-latency Mealy match pulse; matches are counted and the run stops
// in DONE once a non-zero target is reached.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-low reset
//   bus    seq_det_ctrl_if.slave (cfg handshake, start/abort, x/x_valid,
//          z, hit_count, busy, done, cfg_ready, cfg_err)
module seq_det_ctrl #(
    parameter int unsigned MAXLEN = 8,
    parameter int unsigned LENW   = 4,
    parameter int unsigned CNTW   = 8
) (
    input  logic          clk,
    input  logic          reset,
    seq_det_ctrl_if.slave bus
);

    localparam int unsigned      HISTW    = MAXLEN - 1;
    localparam logic [LENW-1:0]  LEN_MAX  = LENW'(MAXLEN);
    localparam logic [LENW-1:0]  FILL_MAX = LENW'(MAXLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [HISTW-1:0]  hist_q;
    logic [LENW-1:0]   fill_q;
    logic [MAXLEN-1:0] pat_q;
    logic [LENW-1:0]   len_q;
    logic              ovl_q;
    logic [CNTW-1:0]   tgt_q;
    logic [CNTW-1:0]   hit_q;
    logic              cfg_ready_q;
    logic              cfg_err_q;
    logic              busy_q;
    logic              done_q;

    logic [MAXLEN-1:0] window_c;
    logic              mismatch_c;
    logic              match_c;
    logic [CNTW-1:0]   hit_inc_c;
    logic              hit_final_c;
    logic              cfg_acc_c;
    logic              cfg_legal_c;

    // Match datapath: compare the low len bits of {history, x} with the pattern.
    always_comb begin
        window_c   = {hist_q, bus.x};
        mismatch_c = 1'b0;
        for (int unsigned i = 0; i < MAXLEN; i++) begin
            if ((LENW'(i) < len_q) && (window_c[i] != pat_q[i])) begin
                mismatch_c = 1'b1;
            end
        end
        // fill >= len-1 guarantees every compared history bit came from this run
        match_c     = (state_q == S_RUN) && bus.x_valid &&
                      (fill_q >= (len_q - LENW'(1))) && !mismatch_c;
        hit_inc_c   = hit_q + CNTW'(1);
        hit_final_c = match_c && (tgt_q != '0) && (hit_inc_c == tgt_q);
        cfg_acc_c   = bus.cfg_valid && cfg_ready_q;
        cfg_legal_c = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_MAX);
    end

    // Controller FSM, configuration registers, history and hit counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            hist_q      <= '0;
            fill_q      <= '0;
            pat_q       <= '0;
            len_q       <= LENW'(1);
            ovl_q       <= 1'b0;
            tgt_q       <= '0;
            hit_q       <= '0;
            cfg_ready_q <= 1'b1;
            cfg_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // cfg_ready is low in RUN, so an accept only happens in IDLE/DONE
            if (cfg_acc_c) begin
                if (cfg_legal_c) begin
                    pat_q     <= bus.cfg_pattern;
                    len_q     <= bus.cfg_len;
                    ovl_q     <= bus.cfg_overlap;
                    tgt_q     <= bus.cfg_target;
                    cfg_err_q <= 1'b0;
                    done_q    <= 1'b0;
                    if (state_q == S_DONE) begin
                        state_q <= S_IDLE;
                    end
                end else begin
                    cfg_err_q <= 1'b1;
                end
            end

            unique case (state_q)
                S_IDLE, S_DONE: begin
                    // a coincident start overrides the DONE->IDLE move above
                    if (bus.start) begin
                        state_q     <= S_RUN;
                        hist_q      <= '0;
                        fill_q      <= '0;
                        hit_q       <= '0;
                        done_q      <= 1'b0;
                        busy_q      <= 1'b1;
                        cfg_ready_q <= 1'b0;
                    end
                end

                S_RUN: begin
                    if (bus.x_valid) begin
                        if (match_c && !ovl_q) begin
                            // non-overlapping: next match needs len fresh bits
                            hist_q <= '0;
                            fill_q <= '0;
                        end else begin
                            hist_q <= HISTW'({hist_q, bus.x});
                            if (fill_q < FILL_MAX) begin
                                fill_q <= fill_q + LENW'(1);
                            end
                        end
                    end

                    if (match_c) begin
                        hit_q <= hit_inc_c;
                    end

                    // reaching the target wins over a simultaneous abort
                    if (hit_final_c) begin
                        state_q     <= S_DONE;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        cfg_ready_q <= 1'b1;
                    end else if (bus.abort) begin
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                        cfg_ready_q <= 1'b1;
                    end
                end

                default: begin
                    state_q     <= S_IDLE;
                    busy_q      <= 1'b0;
                    cfg_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.z         = match_c;
    assign bus.hit_count = hit_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.cfg_ready = cfg_ready_q;
    assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl: stimulus tables of {x, x_valid, abort,
// expected z} are applied one per cycle; each cycle's expected z is queued when
// driven and popped at the falling edge to compare against the DUT.
module tb_seq_det_ctrl;

    localparam int unsigned MAXLEN = 8;
    localparam int unsigned LENW   = 4;
    localparam int unsigned CNTW   = 8;

    typedef struct {
        logic xb;
        logic xv;
        logic ab;
        logic ez;
    } vec_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    seq_det_ctrl_if #(.MAXLEN(MAXLEN), .LENW(LENW), .CNTW(CNTW)) bus ();

    seq_det_ctrl #(.MAXLEN(MAXLEN), .LENW(LENW), .CNTW(CNTW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    int   z_idx    = 0;
    logic sb_q[$];
    logic sb_exp;
    vec_t tbl[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // scoreboard: z is combinational, compare mid-cycle
    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            sb_exp = sb_q.pop_front();
            check($sformatf("z[%0d]", z_idx), int'(bus.z), int'(sb_exp));
            z_idx++;
        end
    end

    task automatic drive(input logic cv, input logic st, input logic ab,
                         input logic xb, input logic xv, input logic ez);
        @(posedge clk);
        #1;
        bus.cfg_valid = cv;
        bus.start     = st;
        bus.abort     = ab;
        bus.x         = xb;
        bus.x_valid   = xv;
        sb_q.push_back(ez);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic cfg_offer(input logic [MAXLEN-1:0] pat, input logic [LENW-1:0] len,
                             input logic ovl, input logic [CNTW-1:0] tgt, input logic st);
        bus.cfg_pattern = pat;
        bus.cfg_len     = len;
        bus.cfg_overlap = ovl;
        bus.cfg_target  = tgt;
        drive(1'b1, st, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // first element in time is bit n-1 of each field
    task automatic add_vecs(input int n, input logic [15:0] xs, input logic [15:0] vs,
                            input logic [15:0] as, input logic [15:0] zs);
        for (int i = n - 1; i >= 0; i--) begin
            vec_t v;
            v.xb = xs[i];
            v.xv = vs[i];
            v.ab = as[i];
            v.ez = zs[i];
            tbl.push_back(v);
        end
    endtask

    task automatic run_tbl();
        foreach (tbl[i]) begin
            drive(1'b0, 1'b0, tbl[i].ab, tbl[i].xb, tbl[i].xv, tbl[i].ez);
        end
        tbl.delete();
    endtask

    task automatic check_outs(input string tag, input int hit, input logic busy,
                              input logic done, input logic rdy, input logic err);
        check({tag, "_hit"},  int'(bus.hit_count), hit);
        check({tag, "_busy"}, int'(bus.busy),      int'(busy));
        check({tag, "_done"}, int'(bus.done),      int'(done));
        check({tag, "_rdy"},  int'(bus.cfg_ready), int'(rdy));
        check({tag, "_err"},  int'(bus.cfg_err),   int'(err));
    endtask

    initial begin
        reset           = 1'b0;
        bus.cfg_valid   = 1'b0;
        bus.cfg_pattern = '0;
        bus.cfg_len     = '0;
        bus.cfg_overlap = 1'b0;
        bus.cfg_target  = '0;
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.x           = 1'b0;
        bus.x_valid     = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check_outs("reset", 0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("reset_z", int'(bus.z), 0);
        reset = 1'b1;

        // 101, non-overlapping, unlimited
        cfg_offer(8'b101, 4'd3, 1'b0, 8'd0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vecs(8, 16'b10101101, 16'hFF, 16'h00, 16'b00100001);
        run_tbl();
        idle();
        check_outs("nonovl", 2, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        check_outs("abort1", 2, 1'b0, 1'b0, 1'b1, 1'b0);

        // overlapping; config accept coincides with start
        cfg_offer(8'b101, 4'd3, 1'b1, 8'd0, 1'b1);
        add_vecs(8, 16'b10101101, 16'hFF, 16'h00, 16'b00101001);
        run_tbl();
        idle();
        check_outs("ovl", 3, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();

        // target of 2 hits
        cfg_offer(8'b101, 4'd3, 1'b1, 8'd2, 1'b1);
        add_vecs(5, 16'b10101, 16'h1F, 16'h00, 16'b00101);
        run_tbl();
        idle();
        check_outs("tgt_done", 2, 1'b0, 1'b1, 1'b1, 1'b0);
        add_vecs(3, 16'b101, 16'h7, 16'h0, 16'h0);
        run_tbl();
        idle();
        check_outs("tgt_hold", 2, 1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        check_outs("restart", 0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        check_outs("abort2", 0, 1'b0, 1'b0, 1'b1, 1'b0);

        // illegal lengths leave the 101/overlap/target=2 config in place
        cfg_offer(8'hFF, 4'd0, 1'b0, 8'd0, 1'b0);
        idle();
        check_outs("len0", 0, 1'b0, 1'b0, 1'b1, 1'b1);
        cfg_offer(8'hFF, 4'(MAXLEN + 1), 1'b0, 8'd1, 1'b0);
        idle();
        check_outs("lenbig", 0, 1'b0, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vecs(3, 16'b101, 16'h7, 16'h0, 16'b001);
        run_tbl();
        idle();
        check_outs("kept_cfg", 1, 1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        cfg_offer(8'b101, 4'd3, 1'b0, 8'd0, 1'b0);
        idle();
        check_outs("legal", 1, 1'b0, 1'b0, 1'b1, 1'b0);

        // gaps with x=1 on invalid cycles, then a config offer during RUN
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vecs(6, 16'b110111, 16'b101001, 16'h0, 16'b000001);
        run_tbl();
        bus.cfg_pattern = 8'b010;
        bus.cfg_len     = 4'd3;
        bus.cfg_overlap = 1'b0;
        bus.cfg_target  = 8'd1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("run_rdy", int'(bus.cfg_ready), 0);
        add_vecs(4, 16'b0101, 16'hF, 16'h0, 16'b0001);
        run_tbl();
        idle();
        check_outs("gaps", 2, 1'b1, 1'b0, 1'b0, 1'b0);

        // reset in the middle of a run
        add_vecs(2, 16'b10, 16'b11, 16'h0, 16'h0);
        run_tbl();
        @(posedge clk);
        #1;
        reset       = 1'b0;
        bus.x_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        check_outs("midreset", 0, 1'b0, 1'b0, 1'b1, 1'b0);

        // reset config is len=1, pattern=0: every valid 0 matches
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vecs(3, 16'b010, 16'h7, 16'h0, 16'b101);
        run_tbl();
        idle();
        check_outs("len1", 2, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();

        // fresh history after start, abort on the hit cycle
        cfg_offer(8'b101, 4'd3, 1'b1, 8'd0, 1'b1);
        add_vecs(4, 16'b1101, 16'hF, 16'b0001, 16'b0001);
        run_tbl();
        idle();
        check_outs("abort_hit", 1, 1'b0, 1'b0, 1'b1, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        check("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
